// File: rtl/cteq_eq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cteq_ctrl_pkg
// Shared types for the CTLE equalizer-zero calibration sequencer.
//   ctrl_state_t : sequencer state encoding
//   eq_code_t    : equalizer code at the default code width
//   ERRCNT_W()   : width needed to count 0..win error samples
// ----------------------------------------------------------------------------
package cteq_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_APPLY   = 3'd1,
        S_SETTLE  = 3'd2,
        S_MEASURE = 3'd3,
        S_COMPARE = 3'd4,
        S_FINAL   = 3'd5,
        S_DONE    = 3'd6
    } ctrl_state_t;

    localparam int EQ_CODE_W = 4;

    typedef logic [EQ_CODE_W-1:0] eq_code_t;

    // Width of a counter that must hold every value from 0 to win inclusive.
    function automatic int ERRCNT_W(input int win);
        return $clog2(win + 1);
    endfunction

endpackage

// File: rtl/cteq_eq_ctrl_if.sv
// ----------------------------------------------------------------------------
// cteq_eq_ctrl_if
// Control/observation bundle of the CTLE calibration sequencer.
//   start, abort      : sweep request / cancel
//   err_valid, err    : slicer error sample stream
//   eq_code           : code driven to the eq_z DAC
//   busy, done        : sequencer status, done is a one-cycle pulse
//   best_code/best_err: result of the last completed sweep
// master = the side issuing requests and errors, slave = the sequencer.
// ----------------------------------------------------------------------------
interface cteq_eq_ctrl_if
    import cteq_ctrl_pkg::*;
#(
    parameter int CODE_W  = EQ_CODE_W,
    parameter int WIN_LEN = 256
) ();

    localparam int ERR_W = ERRCNT_W(WIN_LEN);

    logic              start;
    logic              abort;
    logic              err_valid;
    logic              err;
    logic [CODE_W-1:0] eq_code;
    logic              busy;
    logic              done;
    logic [CODE_W-1:0] best_code;
    logic [ERR_W-1:0]  best_err;

    modport master (
        output start, abort, err_valid, err,
        input  eq_code, busy, done, best_code, best_err
    );

    modport slave (
        input  start, abort, err_valid, err,
        output eq_code, busy, done, best_code, best_err
    );

endinterface

// File: rtl/cteq_eq_ctrl_err_win_counter.sv
// ----------------------------------------------------------------------------
// err_win_counter
// Counts slicer errors over a window of WIN_LEN valid samples.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : restart the window (sample count reloaded, errors cleared)
//   en         : window is open; samples outside it are ignored
//   err_valid  : err is a real sample this cycle
//   err        : 1 = slicer error
//   full       : high in the cycle the last window sample is accepted
//   err_cnt    : errors accumulated in the current window (never > WIN_LEN)
// ----------------------------------------------------------------------------
module err_win_counter
    import cteq_ctrl_pkg::*;
#(
    parameter int WIN_LEN = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           en,
    input  logic                           err_valid,
    input  logic                           err,
    output logic                           full,
    output logic [ERRCNT_W(WIN_LEN)-1:0]   err_cnt
);

    localparam int CNT_W = ERRCNT_W(WIN_LEN);
    localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(WIN_LEN);

    // Samples still needed to close the window; once it reaches zero the
    // window stops accepting, which is what bounds err_cnt at WIN_LEN.
    logic [CNT_W-1:0] samp_left;
    logic             accept;

    assign accept = en && err_valid && (samp_left != '0);
    assign full   = accept && (samp_left == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            samp_left <= WIN_LOAD;
            err_cnt   <= '0;
        end else if (accept) begin
            samp_left <= samp_left - CNT_W'(1);
            err_cnt   <= err_cnt + CNT_W'(err);
        end
    end

endmodule

// File: rtl/cteq_eq_ctrl.sv
// ----------------------------------------------------------------------------
// cteq_eq_ctrl
// Calibration sequencer for the CTLE equalizer zero. Sweeps eq_code from
// CODE_MIN to CODE_MAX, waits SETTLE_CYC cycles after each change, counts
// slicer errors over WIN_LEN valid samples and applies the code with the
// fewest errors (lowest code wins a tie).
//   clk, rst : clock, synchronous active-high reset
//   bus      : cteq_eq_ctrl_if slave (start/abort/err stream in,
//              eq_code/busy/done/best_code/best_err out, all registered)
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for start, eq_code held
// S_APPLY   | cur_code on the DAC, error window cleared
// S_SETTLE  | analog path settling, err ignored
// S_MEASURE | counting errors over WIN_LEN valid samples
// S_COMPARE | keep code if strictly better, step or finish
// S_FINAL   | best code applied, best_code/best_err published
// S_DONE    | done pulse
// ----------------------------------------------------------------------------
module cteq_eq_ctrl
    import cteq_ctrl_pkg::*;
#(
    parameter int CODE_W       = EQ_CODE_W,
    parameter int CODE_MIN     = 0,
    parameter int CODE_MAX     = 15,
    parameter int DEFAULT_CODE = 8,
    parameter int SETTLE_CYC   = 64,
    parameter int WIN_LEN      = 256
) (
    input  logic           clk,
    input  logic           rst,
    cteq_eq_ctrl_if.slave  bus
);

    localparam int ERR_W = ERRCNT_W(WIN_LEN);
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [CODE_W-1:0] C_MIN    = CODE_W'(CODE_MIN);
    localparam logic [CODE_W-1:0] C_MAX    = CODE_W'(CODE_MAX);
    localparam logic [CODE_W-1:0] C_DEF    = CODE_W'(DEFAULT_CODE);
    localparam logic [SET_W-1:0]  SET_LOAD = SET_W'(SETTLE_CYC - 1);

    ctrl_state_t       state;
    logic [CODE_W-1:0] cur_code;
    logic [CODE_W-1:0] ibest_code;
    logic [ERR_W-1:0]  ibest_err;
    logic [SET_W-1:0]  settle_tmr;

    logic              win_clr;
    logic              win_en;
    logic              win_full;
    logic [ERR_W-1:0]  err_cnt;

    logic              better;
    logic [CODE_W-1:0] next_best_code;
    logic [ERR_W-1:0]  next_best_err;
    logic [CODE_W-1:0] code_inc;

    assign win_clr = (state == S_APPLY);
    assign win_en  = (state == S_MEASURE);

    err_win_counter #(
        .WIN_LEN (WIN_LEN)
    ) u_err_win (
        .clk       (clk),
        .rst       (rst),
        .clr       (win_clr),
        .en        (win_en),
        .err_valid (bus.err_valid),
        .err       (bus.err),
        .full      (win_full),
        .err_cnt   (err_cnt)
    );

    // Strict less-than: on a tie the earlier (lower) code stays recorded.
    assign better         = (err_cnt < ibest_err);
    assign next_best_code = better ? cur_code : ibest_code;
    assign next_best_err  = better ? err_cnt  : ibest_err;
    assign code_inc       = cur_code + CODE_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cur_code      <= C_MIN;
            ibest_code    <= C_MIN;
            ibest_err     <= '1;
            settle_tmr    <= '0;
            bus.eq_code   <= C_DEF;
            bus.best_code <= C_DEF;
            bus.best_err  <= '1;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else if (bus.abort && (state != S_IDLE)) begin
            // best_code/best_err deliberately untouched: they belong to the
            // last sweep that actually completed.
            state       <= S_IDLE;
            bus.eq_code <= C_DEF;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        cur_code    <= C_MIN;
                        ibest_code  <= C_MIN;
                        ibest_err   <= '1;
                        bus.eq_code <= C_MIN;
                        bus.busy    <= 1'b1;
                        state       <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    settle_tmr <= SET_LOAD;
                    state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_tmr == '0) begin
                        state <= S_MEASURE;
                    end else begin
                        settle_tmr <= settle_tmr - SET_W'(1);
                    end
                end
                S_MEASURE: begin
                    if (win_full) begin
                        state <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    ibest_code <= next_best_code;
                    ibest_err  <= next_best_err;
                    // Check the end of the range before stepping so cur_code
                    // never wraps when CODE_MAX is the largest code.
                    if (cur_code == C_MAX) begin
                        bus.eq_code   <= next_best_code;
                        bus.best_code <= next_best_code;
                        bus.best_err  <= next_best_err;
                        state         <= S_FINAL;
                    end else begin
                        cur_code    <= code_inc;
                        bus.eq_code <= code_inc;
                        state       <= S_APPLY;
                    end
                end
                S_FINAL: begin
                    bus.done <= 1'b1;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cteq_eq_ctrl.md
# cteq_eq_ctrl

Digital calibration sequencer for the CTLE (`cteq`). It sweeps the equalizer-zero control code over a range, lets the analog path settle at each code, and counts slicer error samples over a fixed window. It then selects the code with the fewest errors. `eq_code` drives the existing code-to-PWL DAC that generates the `eq_z` control voltage; the block itself is purely digital and synthesizable.

## Interface
Parameters:
- `CODE_W`, 4: width of the equalizer code.
- `CODE_MIN`, 0: first code in the sweep.
- `CODE_MAX`, 15: last code in the sweep (`CODE_MAX >= CODE_MIN`).
- `DEFAULT_CODE`, 8: code applied after reset and after abort.
- `SETTLE_CYC`, 64: settle cycles after each code change (≥1).
- `WIN_LEN`, 256: valid error samples counted per code (≥1).

Ports:
- `clk`, in, 1: clock; all logic is rising-edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin a sweep; sampled only in IDLE.
- `abort`, in, 1: cancel a sweep; highest priority after `rst`.
- `err_valid`, in, 1: `err` is valid this cycle.
- `err`, in, 1: slicer error sample (1 = error).
- `eq_code`, out, CODE_W: code currently applied to the DAC.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse when a sweep completes.
- `best_code`, out, CODE_W: winning code, held until the next sweep completes.
- `best_err`, out, clog2(WIN_LEN+1): error count of `best_code`, held with it.

## Operation
- The states are IDLE, APPLY, SETTLE, MEASURE, COMPARE, FINAL and DONE.
- Reset puts the block in IDLE with `eq_code=DEFAULT_CODE`, `best_code=DEFAULT_CODE`, `best_err` all-ones, and `busy=done=0`.
- IDLE: when `start=1`, load `cur_code=CODE_MIN` and set the internal best count to all-ones, then go to APPLY.
- APPLY (1 cycle): `eq_code=cur_code`, clear the error and sample counters, then go to SETTLE.
- SETTLE (SETTLE_CYC cycles): `err` is ignored. After the last settle cycle, go to MEASURE.
- MEASURE: each cycle with `err_valid=1` increments the sample counter and adds `err` to the error counter.
  - Samples without `err_valid` are not counted.
  - Leave for COMPARE in the cycle the WIN_LEN-th valid sample is accepted.
  - The error counter cannot exceed WIN_LEN.
- COMPARE (1 cycle):
  - If the error count is strictly less than the internal best, record `cur_code` and the count as the new best.
  - On a tie, the lower code (the one recorded first) is kept.
  - If `cur_code==CODE_MAX`, go to FINAL; otherwise increment `cur_code` and go to APPLY.
- FINAL (1 cycle): `eq_code` = internal best code; the `best_code`/`best_err` outputs are updated; then go to DONE.
- DONE (1 cycle): `done=1`, `eq_code` is held, then go to IDLE. IDLE keeps holding `eq_code`.
- `abort` in any non-IDLE state moves to IDLE on the next edge:
  - `eq_code=DEFAULT_CODE`;
  - `best_code`/`best_err` keep their previous values;
  - `done` is not asserted.
- `abort` in IDLE has no effect.
- `start` while busy is ignored.
- If `start` and `abort` are high in the same IDLE cycle, `abort` wins and no sweep begins.
- `rst` mid-sweep gives the full reset values on the next edge.
- `cur_code` never wraps: the CODE_MAX check happens before the increment.

## Timing
- All outputs are registered. `eq_code` changes only on the edge entering APPLY, FINAL, or IDLE via abort/reset.
- Cycles per code = 2 + SETTLE_CYC + MEASURE length; MEASURE length equals WIN_LEN when `err_valid` is held high.
- With `err_valid` constantly high, `done` is high in cycle N·(2+SETTLE_CYC+WIN_LEN)+2 after the cycle `start` is sampled, where N = CODE_MAX−CODE_MIN+1.
- `busy` rises the cycle after `start` is sampled and falls in the cycle after `done`.

## Structure
- Package `cteq_ctrl_pkg`:
  - the `ctrl_state_t` enum;
  - the `eq_code_t` typedef;
  - the `ERRCNT_W(win)` width function (clog2(win+1)).
- Sub-module `err_win_counter`: clear, `err_valid`/`err` inputs, a `full` flag, and the error count output. It is reused for the later DFE adaptation block.

## Test plan
- **Basic sweep.** Parameters CODE 0..3, SETTLE_CYC=4, WIN_LEN=8; `err_valid`=1; error rate per code is 5,2,6,3 of 8.
  - `best_code=1`, `best_err=2`, `eq_code=1`.
  - `done` high exactly 58 cycles after `start` is sampled, then `busy` falls.
- **Tie.** Codes 1 and 3 both give 2 errors → `best_code=1`.
- **Sparse valid.** `err_valid` on alternate cycles → same result as the basic sweep, with MEASURE lasting 16 cycles per code.
- **Abort mid-sweep.** Assert `abort` during MEASURE of code 2 → next cycle IDLE, `eq_code=8`, `best_*` unchanged, no `done` pulse. A following `start` completes normally.
- **Reset mid-sweep.** Assert `rst` in SETTLE → all reset values on the next edge; `start` held during `rst` has no effect.
- **Ignored requests and saturation.**
  - `start` pulsed while busy is ignored.
  - `start` and `abort` together in IDLE leaves `busy` low.
  - A code with `err` always 1 yields count 8 and is never chosen over a lower count.
